// File: rtl/prio_scan_encoder.sv
`default_nettype none
// ============================================================================
// prio_scan_encoder
// Registers a request vector and emits each set-bit position as one beat,
// lowest index first (highest first when PRIO_SCAN_MSB_FIRST_EN is defined).
// Revision: 1.0
// ============================================================================
module prio_scan_encoder #(
  parameter int WIDTH = 8,
  parameter int POS_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [POS_W-1:0] out_pos,
  output logic [POS_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_none
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   pending_q, pending_d;
  logic [POS_W-1:0]   idx_q, idx_d;
  logic               none_q, none_d;

  logic [POS_W-1:0]   w_pos;
  logic               w_last;
  logic               w_scan;
  logic               w_beat_done;
  logic               w_accept;

  // Later loop iterations override earlier ones, so the scan direction
  // decides which set bit wins.
  always_comb begin
    w_pos = '0;
`ifdef PRIO_SCAN_MSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++) begin
      if (pending_q[i]) w_pos = POS_W'(i);
    end
`else
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending_q[i]) w_pos = POS_W'(i);
    end
`endif
  end

  // At most one bit set: clearing the lowest set bit leaves nothing.
  assign w_last      = ~|(pending_q & (pending_q - WIDTH'(1)));
  assign w_scan      = (state_q == S_SCAN);
  assign w_beat_done = w_scan && out_ready;

  assign out_valid = w_scan;
  assign out_pos   = w_scan ? w_pos : '0;
  assign out_idx   = idx_q;
  assign out_last  = w_scan && w_last;
  assign out_none  = w_scan && none_q;

  assign in_ready  = (state_q == S_IDLE) || (w_beat_done && w_last);
  assign w_accept  = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    idx_d     = idx_q;
    none_d    = none_q;

    if (w_beat_done) begin
      pending_d = pending_q & ~(WIDTH'(1) << w_pos);
      idx_d     = idx_q + POS_W'(1);
      if (w_last) begin
        state_d = S_IDLE;
        idx_d   = '0;
        none_d  = 1'b0;
      end
    end

    // Covers both a fresh start from IDLE and a reload on the final beat.
    if (w_accept) begin
      state_d   = S_SCAN;
      pending_d = in_vec;
      idx_d     = '0;
      none_d    = (in_vec == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      idx_q     <= '0;
      none_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      none_q    <= none_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prio_scan_encoder.sv
`default_nettype none
// ============================================================================
// tb_prio_scan_encoder
// Scoreboard bench: accepted vectors are expanded into expected beats by a
// reference model; a monitor compares every presented beat.
// Revision: 1.0
// ============================================================================
module tb_prio_scan_encoder;

  localparam int WIDTH = 8;
  localparam int POS_W = $clog2(WIDTH);

  typedef struct packed {
    logic [POS_W-1:0] pos;
    logic [POS_W-1:0] idx;
    logic             last;
    logic             none;
  } beat_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [POS_W-1:0] out_pos;
  logic [POS_W-1:0] out_idx;
  logic             out_last;
  logic             out_none;

  beat_t exp_q[$];
  beat_t stage_q[$];
  int    checks   = 0;
  int    failures = 0;
  bit    rand_ready = 1'b0;

  prio_scan_encoder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pos   (out_pos),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_none  (out_none)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: list the set positions, order them, number them.
  function automatic void expand(input logic [WIDTH-1:0] v);
    int    plist[$];
    beat_t b;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) plist.push_back(i);
    end
`ifdef PRIO_SCAN_MSB_FIRST_EN
    plist.reverse();
`endif
    if (plist.size() == 0) begin
      b.pos = '0; b.idx = '0; b.last = 1'b1; b.none = 1'b1;
      stage_q.push_back(b);
    end else begin
      foreach (plist[k]) begin
        b.pos  = POS_W'(plist[k]);
        b.idx  = POS_W'(k);
        b.last = (k == plist.size() - 1);
        b.none = 1'b0;
        stage_q.push_back(b);
      end
    end
  endfunction

  // Monitor: beats staged at an acceptance become visible the next cycle.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      stage_q.delete();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_pos", out_pos, 0);
      check("rst_out_idx", out_idx, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_none", out_none, 0);
    end else begin
      while (stage_q.size() > 0) exp_q.push_back(stage_q.pop_front());
      check("out_valid", out_valid, exp_q.size() > 0);
      if (out_valid && exp_q.size() > 0) begin
        check("out_pos", out_pos, exp_q[0].pos);
        check("out_idx", out_idx, exp_q[0].idx);
        check("out_last", out_last, exp_q[0].last);
        check("out_none", out_none, exp_q[0].none);
        check("in_ready_scan", in_ready, out_ready && exp_q[0].last);
        if (out_ready) void'(exp_q.pop_front());
      end else if (!out_valid) begin
        check("in_ready_idle", in_ready, 1);
      end
      if (in_valid && in_ready) expand(in_vec);
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Present a vector until accepted; keep_valid leaves in_valid high so the
  // following send can follow with no gap.
  task automatic send(input logic [WIDTH-1:0] v, input bit keep_valid);
    bit accepted = 1'b0;
    in_vec   = v;
    in_valid = 1'b1;
    for (int c = 0; c < 200 && !accepted; c++) begin
      @(negedge clk);
      accepted = in_ready;
    end
    if (!accepted) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!keep_valid) begin
      in_valid = 1'b0;
      in_vec   = WIDTH'($urandom);
    end
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int c = 0; c < 500 && !done; c++) begin
      @(negedge clk);
      #1;
      done = (exp_q.size() == 0) && (stage_q.size() == 0) && !out_valid;
    end
    if (!done) check("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    out_ready = 1'b1;
    send(8'b0010_1100, 1'b0);
    send(8'h00, 1'b0);
    send(8'h01, 1'b0);
    drain();

    // Hold the first beat of 0x81 under backpressure, twice.
    for (int r = 0; r < 2; r++) begin
      out_ready = 1'b0;
      send(8'h81, 1'b0);
      in_vec = (r == 0) ? 8'h00 : 8'hFF;
      repeat (3) @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain();
    end

    send(8'h06, 1'b1);
    send(8'h40, 1'b0);
    drain();

    // Reset in the middle of the second beat of 0xFF.
    send(8'hFF, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    drain();

    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      logic [WIDTH-1:0] v;
      int sel;
      sel = $urandom_range(0, 7);
      v   = (sel == 0) ? '0 : (sel == 1) ? '1 : WIDTH'($urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(v, 1'b0);
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/prio_scan_encoder.md
Name: prio_scan_encoder

Overview:
- Parametrised, sequential successor to the team's combinational 8-bit lowest-set-bit priority encoder.
- Accepts a WIDTH-bit request vector over a valid/ready handshake and registers it.
- Emits the position of every set bit, one per output beat, lowest index first, with a last flag and beat index.
- Sits between request-collection logic and a per-request serial consumer, e.g. an interrupt or arbiter grant sequencer.

Parameters:
- WIDTH, 8: request vector width; must be 2 or more.
- POS_W, $clog2(WIDTH): width of out_pos and out_idx; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  request vector valid
- in_ready  output  1  block can accept a vector
- in_vec  input  WIDTH  request vector
- out_valid  output  1  out_pos/out_idx/out_last/out_none are valid
- out_ready  input  1  consumer accepts the current beat
- out_pos  output  POS_W  bit position of the current set bit
- out_idx  output  POS_W  beat number within the current vector, starting at 0
- out_last  output  1  current beat is the final beat for this vector
- out_none  output  1  captured vector was all-zero

Behaviour:
- Interface: one clock; reset is asynchronous and active-high, on port reset.
- Reset values: state=IDLE, pending vector=0, out_valid=0, out_pos=0, out_idx=0, out_last=0, out_none=0; in_ready=1 once reset deasserts.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid, capture in_vec into pending and go to SCAN.
  - SCAN: out_valid=1.
    - out_pos = index of the lowest set bit of pending.
    - out_last = 1 when pending has at most one set bit.
    - On out_valid&&out_ready: clear that bit in pending and increment out_idx.
    - If out_last, go to IDLE, or reload directly (see back-to-back).
- Latency: vector accepted at edge N gives first beat valid after edge N (visible in cycle N+1). Each subsequent beat appears one cycle after the previous beat is accepted.
- Zero vector: produce exactly one beat with out_pos=0, out_idx=0, out_last=1, out_none=1.
  - This differs from the old encoder, which could not distinguish "bit 0" from "none".
- Bit 0 set is a real position: out_pos=0 with out_none=0.
- Back-to-back: in_ready = IDLE || (out_valid && out_ready && out_last), a combinational path from out_ready.
  - If a new vector is accepted on the same edge the last beat retires, SCAN is re-entered directly with out_idx=0. There is no bubble.
- Backpressure: while out_valid && !out_ready, out_pos, out_idx, out_last and out_none hold stable. in_vec is ignored.
- in_vec is sampled only on in_valid&&in_ready. Later changes to in_vec have no effect on the vector in flight.
- Full vector: WIDTH beats with out_idx 0..WIDTH-1, where out_pos equals out_idx. Only beat WIDTH-1 has out_last=1.
  - out_idx wraps naturally; it never exceeds WIDTH-1 by construction.
- Reset mid-scan: all state clears immediately (asynchronous). The pending vector is discarded and no partial beat is emitted after release.
- Position computation is a parametrised loop over WIDTH. No hard-coded case items.

Optional Feature:
- Macro: PRIO_SCAN_MSB_FIRST_EN.
- Defined: beats are emitted highest set index first. out_pos = index of the highest set bit of pending, and that bit is cleared on acceptance. out_idx, out_last, out_none and handshake behaviour are unchanged.
- Undefined: lowest index first, as described above.

Test Plan:
- WIDTH=8, in_vec=8'b0010_1100, out_ready=1 -> three beats, out_pos 2,3,5; out_idx 0,1,2; out_last only on pos 5; in_ready returns to 1.
- in_vec=8'h00 -> single beat: out_pos=0, out_none=1, out_last=1.
- in_vec=8'h01 -> single beat: out_pos=0, out_none=0.
- in_vec=8'h81 with out_ready low for 3 cycles on the first beat -> out_pos=0 is held for 3 cycles, then beat out_pos=7 with out_last=1.
  - In a second run, change in_vec after acceptance -> no effect on the emitted beats.
- Back-to-back: 8'h06, then 8'h40 held valid -> beats 1, 2(last), 6(last) on consecutive cycles with no idle cycle.
- Assert reset during the second beat of 8'hFF -> out_valid=0 and in_ready=1 right after release.
  - Repeat with WIDTH=16, in_vec=16'h8001 -> pos 0 then 15.
  - With PRIO_SCAN_MSB_FIRST_EN defined -> pos 15 then 0.
